// File: rtl/jt51_regwr_pkg.sv
// Shared types for the jt51 register-write initiator: FSM states, status bit index, command pair.
package jt51_regwr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR_WR,
    ST_GAP,
    ST_DATA_WR,
    ST_SETTLE,
    ST_POLL
  } state_t;

  localparam int STATUS_BUSY = 7;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } pair_t;

endpackage

// File: rtl/jt51_regwr_if.sv
// Command queue handshake plus the jt51 CPU bus; slave is the writer's view, master the host/chip side.
interface jt51_regwr_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_addr;
  logic [7:0] cmd_data;
  logic       cs_n;
  logic       wr_n;
  logic       a0;
  logic [7:0] dout;
  logic [7:0] din;

  modport master (
    output cmd_valid, cmd_addr, cmd_data, din,
    input  cmd_ready, cs_n, wr_n, a0, dout
  );

  modport slave (
    input  cmd_valid, cmd_addr, cmd_data, din,
    output cmd_ready, cs_n, wr_n, a0, dout
  );
endinterface

// File: rtl/jt51_regwr_fifo.sv
// Single-clock FIFO of command pairs; pointers wrap naturally because DEPTH is a power of two.
module jt51_regwr_fifo
  import jt51_regwr_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  pair_t                  i_wdat,
  output pair_t                  o_rdat,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_level
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  pair_t         r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_cnt;
  logic          w_wr;
  logic          w_rd;

  assign o_full  = (r_cnt == FULL_CNT);
  assign o_empty = (r_cnt == '0);
  assign o_level = r_cnt;
  assign o_rdat  = r_mem[r_rptr];
  assign w_wr    = i_push & ~o_full;
  assign w_rd    = i_pop & ~o_empty;

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= i_wdat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + AW'(1);
      if (w_rd) r_rptr <= r_rptr + AW'(1);
      r_cnt <= r_cnt + (AW+1)'(w_wr) - (AW+1)'(w_rd);
    end
  end
endmodule

// File: rtl/jt51_regwr.sv
// Replays queued (addr,data) pairs on the jt51 CPU bus and polls busy after each data write.
// Optional macro JT51_REGWR_TIMEOUT_EN bounds the busy poll and adds the sticky timeout_err flag.
module jt51_regwr
  import jt51_regwr_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int WR_CYCLES    = 2,
  parameter int SETTLE       = 4,
  parameter int BUSY_TIMEOUT = 1023
) (
  input  logic                   clk,
  input  logic                   rst,
  jt51_regwr_if.slave            bus,
  output logic                   idle,
  output logic [$clog2(DEPTH):0] level,
  output logic                   timeout_err,
  input  logic                   err_clr
);
  localparam int LW     = $clog2(DEPTH) + 1;
  localparam int PH_MAX = (WR_CYCLES > SETTLE) ? WR_CYCLES : SETTLE;
  localparam int PW     = $clog2(PH_MAX + 1);

  state_t        r_state, w_state_nxt;
  logic [PW-1:0] r_phase;
  pair_t         w_cmd, w_head, w_cur, r_pair;
  logic          w_full, w_empty, w_push, w_pop, w_to_hit;
  logic [LW-1:0] w_level, w_level_nxt;
  logic          r_rdy, r_idle, r_cs_n, r_wr_n, r_a0;
  logic [7:0]    r_dout;
  logic          w_cs_n, w_wr_n, w_a0;
  logic [7:0]    w_dout;
  logic          w_unused_din;

  assign w_cmd.addr   = bus.cmd_addr;
  assign w_cmd.data   = bus.cmd_data;
  assign w_push       = bus.cmd_valid & r_rdy & ~w_full;
  assign w_pop        = (r_state == ST_IDLE) & ~w_empty;
  assign w_level_nxt  = w_level + LW'(w_push) - LW'(w_pop);
  assign w_cur        = w_pop ? w_head : r_pair;
  assign w_unused_din = &{1'b0, bus.din[6:0]};

  jt51_regwr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdat  (w_cmd),
    .o_rdat  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (!w_empty) w_state_nxt = ST_ADDR_WR;
      ST_ADDR_WR: if (r_phase == PW'(WR_CYCLES - 1)) w_state_nxt = ST_GAP;
      ST_GAP:     w_state_nxt = ST_DATA_WR;
      ST_DATA_WR: if (r_phase == PW'(WR_CYCLES - 1)) w_state_nxt = ST_SETTLE;
      ST_SETTLE:  if (r_phase == PW'(SETTLE - 1)) w_state_nxt = ST_POLL;
      ST_POLL:    if (!bus.din[STATUS_BUSY] || w_to_hit) w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  // Bus values are derived from the next state so every pin comes straight off a flop.
  always_comb begin
    w_cs_n = 1'b1;
    w_wr_n = 1'b1;
    w_a0   = r_a0;
    w_dout = r_dout;
    case (w_state_nxt)
      ST_ADDR_WR: begin w_cs_n = 1'b0; w_wr_n = 1'b0; w_a0 = 1'b0; w_dout = w_cur.addr; end
      ST_GAP:     w_a0 = 1'b0;
      ST_DATA_WR: begin w_cs_n = 1'b0; w_wr_n = 1'b0; w_a0 = 1'b1; w_dout = w_cur.data; end
      ST_SETTLE:  w_a0 = 1'b1;
      ST_POLL:    begin w_cs_n = 1'b0; w_a0 = 1'b1; end
      default:    ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_phase <= '0;
      r_pair  <= '0;
      r_rdy   <= 1'b0;
      r_idle  <= 1'b0;
      r_cs_n  <= 1'b1;
      r_wr_n  <= 1'b1;
      r_a0    <= 1'b0;
      r_dout  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_phase <= (w_state_nxt != r_state) ? '0 : r_phase + PW'(1);
      if (w_pop) r_pair <= w_head;
      r_rdy   <= (w_level_nxt != LW'(DEPTH));
      r_idle  <= (w_state_nxt == ST_IDLE) && (w_level_nxt == '0);
      r_cs_n  <= w_cs_n;
      r_wr_n  <= w_wr_n;
      r_a0    <= w_a0;
      r_dout  <= w_dout;
    end
  end

`ifdef JT51_REGWR_TIMEOUT_EN
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);
  logic [TW-1:0] r_poll;
  logic          r_terr;

  assign w_to_hit = (r_state == ST_POLL) & bus.din[STATUS_BUSY] & (r_poll == TW'(BUSY_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_poll <= '0;
      r_terr <= 1'b0;
    end else begin
      r_poll <= (r_state == ST_POLL && w_state_nxt == ST_POLL) ? r_poll + TW'(1) : '0;
      if (w_to_hit)     r_terr <= 1'b1;
      else if (err_clr) r_terr <= 1'b0;
    end
  end
  assign timeout_err = r_terr;
`else
  localparam int unused_busy_timeout = BUSY_TIMEOUT;
  logic w_unused_clr;
  assign w_unused_clr = &{1'b0, err_clr};
  assign w_to_hit     = 1'b0;
  assign timeout_err  = 1'b0;
`endif

  assign bus.cmd_ready = r_rdy;
  assign bus.cs_n      = r_cs_n;
  assign bus.wr_n      = r_wr_n;
  assign bus.a0        = r_a0;
  assign bus.dout      = r_dout;
  assign idle          = r_idle;
  assign level         = w_level;
endmodule
